// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch sequencer: FSM states, redirect modes, PC step.
package fetch_pkg;

   typedef enum logic [1:0] {
      RESET = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [1:0] MODE_BRANCH = 2'd0;
   localparam logic [1:0] MODE_JUMP   = 2'd1;
   localparam logic [1:0] MODE_REG    = 2'd2;

   localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/fetch_target_calc.sv
// Combinational redirect target: branch, jump and jump-register, plus jr misalignment.
module fetch_target_calc
   import fetch_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] src_pc,
   input  logic [25:0]       imm,
   input  logic [ADDR_W-1:0] reg_val,
   output logic [ADDR_W-1:0] target,
   output logic              misaligned
);

   logic [ADDR_W-1:0] pc4;
   logic [ADDR_W-1:0] br_off;
   logic [ADDR_W-1:0] jmp_low;
   logic [ADDR_W-1:0] hi_mask;

   assign pc4     = src_pc + ADDR_W'(PC_STEP);
   assign br_off  = {{(ADDR_W-18){imm[15]}}, imm[15:0], 2'b00};
   // Jump keeps the region bits above bit 27 of the delay-slot address.
   assign jmp_low = ADDR_W'({imm, 2'b00});
   assign hi_mask = ~ADDR_W'(28'hFFF_FFFF);

   always_comb begin
      target     = '0;
      misaligned = 1'b0;
      case (mode)
         MODE_BRANCH: target = pc4 + br_off;
         MODE_JUMP:   target = (pc4 & hi_mask) | jmp_low;
         MODE_REG: begin
            target     = {reg_val[ADDR_W-1:2], 2'b00};
            misaligned = |reg_val[1:0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/fetch_sequencer.sv
// PC owner and instruction fetcher with hardware redirects and in-flight squash.
// Define FETCH_DELAY_SLOT_EN to keep the instruction at src_pc+4 (MIPS delay slot).
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                INSTR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr_out,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic [ADDR_W-1:0]  instr_pc4,
   input  logic               redirect_valid,
   input  logic [1:0]         redirect_mode,
   input  logic [ADDR_W-1:0]  redirect_src_pc,
   input  logic [25:0]        redirect_imm,
   input  logic [ADDR_W-1:0]  redirect_reg,
   output logic               align_fault,
   output logic [31:0]        instr_count,
   output logic [1:0]         dbg_state
);

   // Handshakes: imem_req/imem_addr hold until the one-cycle imem_ack; an
   // instruction transfers to decode on any cycle with instr_valid && instr_ready.

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] fetch_addr, pend_target, target;
   logic              pend, pend_drop, misaligned;
   logic              redir, keep, squash, ack_ok;

   fetch_target_calc #(.ADDR_W(ADDR_W)) u_target (
      .mode       (redirect_mode),
      .src_pc     (redirect_src_pc),
      .imm        (redirect_imm),
      .reg_val    (redirect_reg),
      .target     (target),
      .misaligned (misaligned)
   );

   assign redir = redirect_valid && (redirect_mode != 2'd3) && (state != RESET);

`ifdef FETCH_DELAY_SLOT_EN
   logic [ADDR_W-1:0] cur_pc;
   assign cur_pc = (state == HOLD) ? instr_pc : fetch_addr;
   assign keep   = redir && (cur_pc == redirect_src_pc + ADDR_W'(PC_STEP));
`else
   assign keep   = 1'b0;
`endif

   assign squash = redir && !keep;
   // pend_drop marks an in-flight fetch whose data must be thrown away.
   assign ack_ok = (state == FETCH) && imem_ack && !squash && !(pend && pend_drop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RESET;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RESET: state_nxt = FETCH;
         FETCH: if (ack_ok) state_nxt = HOLD;
         HOLD:  if (squash || instr_ready) state_nxt = FETCH;
         default: state_nxt = RESET;
      endcase
   end

   always_comb begin
      imem_req    = (state == FETCH);
      instr_valid = (state == HOLD);
      dbg_state   = state;
   end

   assign imem_addr = fetch_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_addr  <= RESET_VEC;
         pend_target <= RESET_VEC;
         pend        <= 1'b0;
         pend_drop   <= 1'b0;
         instr_out   <= '0;
         instr_pc    <= RESET_VEC;
         instr_pc4   <= RESET_VEC + ADDR_W'(PC_STEP);
         align_fault <= 1'b0;
         instr_count <= '0;
      end else begin
         if (redir && misaligned) align_fault <= 1'b1;
         case (state)
            RESET: fetch_addr <= RESET_VEC;
            FETCH: begin
               if (imem_ack) begin
                  if (squash) begin
                     fetch_addr <= target;
                     pend       <= 1'b0;
                     pend_drop  <= 1'b0;
                  end else if (pend && pend_drop) begin
                     fetch_addr <= pend_target;
                     pend       <= 1'b0;
                     pend_drop  <= 1'b0;
                  end else begin
                     instr_out <= imem_rdata;
                     instr_pc  <= fetch_addr;
                     instr_pc4 <= fetch_addr + ADDR_W'(PC_STEP);
                     if (redir) begin
                        pend        <= 1'b1;
                        pend_drop   <= 1'b0;
                        pend_target <= target;
                     end
                  end
               end else if (redir) begin
                  // Latest redirect wins; the outstanding fetch stays dropped once marked.
                  pend        <= 1'b1;
                  pend_drop   <= pend_drop | squash;
                  pend_target <= target;
               end
            end
            HOLD: begin
               if (squash) begin
                  fetch_addr <= target;
                  pend       <= 1'b0;
                  pend_drop  <= 1'b0;
               end else if (instr_ready) begin
                  instr_count <= instr_count + 32'd1;
                  fetch_addr  <= redir ? target : (pend ? pend_target : instr_pc4);
                  pend        <= 1'b0;
                  pend_drop   <= 1'b0;
               end else if (redir) begin
                  pend        <= 1'b1;
                  pend_drop   <= 1'b0;
                  pend_target <= target;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
